// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_e;

  localparam int NREQ_DEF    = 4;
  localparam int WIDTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester above last_i, wrapping around.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] win_o,
  output logic            any_o
);
  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest valid requester overwrites.
  always_comb begin
    win_o = '0;
    idx   = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IW'((int'(last_i) + off) % NREQ);
      if (req_i[idx]) begin
        win_o      = '0;
        win_o[idx] = 1'b1;
      end
    end
  end

  assign any_o = |req_i;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter feeding one FIFO write port.
// Optional mid-frame stall timeout is enabled with `define FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_w_en,
  output logic [WIDTH-1:0]      fifo_data,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
`ifdef FIFO_ARB_TIMEOUT_EN
  ,
  output logic                  timeout_flag
`endif
);
  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_wr_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] win;
  logic            any_req;
  logic [IW-1:0]   owner_idx;
  logic [WIDTH-1:0] owner_data;
  logic            owner_valid, owner_last, beat;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any_req)
  );

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = IW'(i);
        owner_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);
  assign beat        = (state_q == XFER) & owner_valid & ~fifo_full;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall, to_hit;

  // Only cycles where the owner itself has nothing to send count toward the limit.
  assign stall  = (state_q == XFER) & ~owner_valid & ~fifo_full;
  assign to_hit = stall & (cnt_q == CW'(TIMEOUT - 1));
  assign cnt_d  = (stall && !to_hit) ? cnt_q + CW'(1) : '0;
  assign timeout_flag = to_hit;

  always_ff @(posedge clk) begin
    if (srst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = XFER;
          grant_d = win;
        end
      end
      XFER: begin
        if (beat && owner_last) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end
`ifdef FIFO_ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == XFER);
    grant     = grant_q;
    req_ready = busy ? (grant_q & {NREQ{~fifo_full}}) : '0;
    fifo_w_en = beat;
    fifo_data = busy ? owner_data : '0;
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; FIFO writes are checked by a scoreboard monitor.
module tb_fifo_wr_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int EW      = 2 + WIDTH;

  logic                  clk = 1'b0;
  logic                  srst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_w_en;
  logic [WIDTH-1:0]      fifo_data;
  logic [NREQ-1:0]       grant;
  logic                  busy;
`ifdef FIFO_ARB_TIMEOUT_EN
  logic                  timeout_flag;
`endif

  // Expected FIFO writes, each entry is {owner index, word}.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [NREQ-1:0] mon_oh;
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .srst         (srst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data    (fifo_data),
    .grant        (grant),
    .busy         (busy)
`ifdef FIFO_ARB_TIMEOUT_EN
    ,
    .timeout_flag (timeout_flag)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic l, input logic [WIDTH-1:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic push(input int i, input logic [WIDTH-1:0] d);
    exp_q.push_back({2'(i), d});
  endtask

  // Monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && fifo_w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got write of %0h by grant %0b, expected no write", fifo_data, grant);
      end else begin
        mon_e = exp_q.pop_front();
        mon_oh = '0;
        mon_oh[mon_e[EW-1:WIDTH]] = 1'b1;
        check("beat_data", fifo_data, mon_e[WIDTH-1:0]);
        check("beat_owner", grant, mon_oh);
      end
    end
  end

  initial begin
    int g_exp[9];
    g_exp = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wen", fifo_w_en, 0);
    mon_en = 1'b1;
    tick();
    srst = 1'b0;

    // All four requesters with single-word frames: round-robin with idle gaps
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b1, 4'hA + 4'(i));
    push(0, 4'hA); push(1, 4'hB); push(2, 4'hC); push(3, 4'hD); push(0, 4'hA);
    @(negedge clk);
    check("rr_grant_c0", grant, 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      @(negedge clk);
      check("rr_grant_seq", grant, g_exp[k]);
    end
    tick();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    check("rr_end_busy", busy, 0);

    // Requester 2 three-word frame with FIFO full on the second XFER cycle
    tick();
    drive(2, 1'b1, 1'b0, 4'hA);
    push(2, 4'hA); push(2, 4'hB); push(2, 4'hC);
    @(negedge clk);
    check("full_idle_wen", fifo_w_en, 0);
    tick();
    @(negedge clk);
    check("full_grant_c1", grant, 4'b0100);
    check("full_wen_c1", fifo_w_en, 1);
    tick();
    drive(2, 1'b1, 1'b0, 4'hB);
    fifo_full = 1'b1;
    @(negedge clk);
    check("full_wen_c2", fifo_w_en, 0);
    check("full_ready_c2", req_ready, 0);
    check("full_grant_c2", grant, 4'b0100);
    tick();
    fifo_full = 1'b0;
    @(negedge clk);
    check("full_wen_c3", fifo_w_en, 1);
    check("full_ready_c3", req_ready, 4'b0100);
    tick();
    drive(2, 1'b1, 1'b1, 4'hC);
    @(negedge clk);
    check("full_wen_c4", fifo_w_en, 1);
    tick();
    drive(2, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    check("full_end_busy", busy, 0);
    check("full_end_grant", grant, 0);

    // Requester 3 waits while requester 1 finishes its frame
    tick();
    drive(1, 1'b1, 1'b0, 4'h1);
    push(1, 4'h1); push(1, 4'h2); push(1, 4'h3); push(3, 4'h7);
    tick();
    @(negedge clk);
    check("nonown_grant_c1", grant, 4'b0010);
    tick();
    drive(1, 1'b1, 1'b0, 4'h2);
    drive(3, 1'b1, 1'b1, 4'h7);
    @(negedge clk);
    check("nonown_ready3_c2", req_ready[3], 0);
    check("nonown_grant_c2", grant, 4'b0010);
    tick();
    drive(1, 1'b1, 1'b1, 4'h3);
    @(negedge clk);
    check("nonown_ready3_c3", req_ready[3], 0);
    tick();
    drive(1, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    check("nonown_gap_grant", grant, 0);
    check("nonown_gap_ready", req_ready, 0);
    tick();
    @(negedge clk);
    check("nonown_grant3", grant, 4'b1000);
    check("nonown_ready3", req_ready, 4'b1000);
    tick();
    drive(3, 1'b0, 1'b0, 4'h0);

    // Reset mid-frame, then the lowest valid requester wins
    tick();
    drive(1, 1'b1, 1'b1, 4'h5);
    push(1, 4'h5);
    tick();
    @(negedge clk);
    check("mrst_pre_grant", grant, 4'b0010);
    tick();
    drive(1, 1'b0, 1'b0, 4'h0);
    drive(2, 1'b1, 1'b0, 4'h8);
    push(2, 4'h8); push(2, 4'h9);
    tick();
    @(negedge clk);
    check("mrst_grant2", grant, 4'b0100);
    tick();
    drive(2, 1'b1, 1'b0, 4'h9);
    srst = 1'b1;
    @(negedge clk);
    check("mrst_word2_wen", fifo_w_en, 1);
    tick();
    srst = 1'b0;
    drive(1, 1'b1, 1'b1, 4'h6);
    drive(2, 1'b1, 1'b0, 4'hE);
    push(1, 4'h6);
    @(negedge clk);
    check("mrst_after_grant", grant, 0);
    check("mrst_after_wen", fifo_w_en, 0);
    check("mrst_after_busy", busy, 0);
    tick();
    @(negedge clk);
    check("mrst_first_grant", grant, 4'b0010);
    tick();
    drive(1, 1'b0, 1'b0, 4'h0);
    drive(2, 1'b1, 1'b1, 4'hE);
    push(2, 4'hE);
    @(negedge clk);
    check("mrst_gap_busy", busy, 0);
    tick();
    @(negedge clk);
    check("mrst_next_grant", grant, 4'b0100);
    tick();
    drive(2, 1'b0, 1'b0, 4'h0);

    // Owner drops valid mid-frame while requester 1 waits
    tick();
    drive(0, 1'b1, 1'b0, 4'h3);
    push(0, 4'h3);
    tick();
    @(negedge clk);
    check("stall_grant_c1", grant, 4'b0001);
    tick();
    drive(0, 1'b0, 1'b0, 4'h0);
    drive(1, 1'b1, 1'b1, 4'h4);
`ifdef FIFO_ARB_TIMEOUT_EN
    push(1, 4'h4);
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      check("to_hold_grant", grant, 4'b0001);
      check("to_flag", timeout_flag, (k == TIMEOUT) ? 1 : 0);
    end
    tick();
    @(negedge clk);
    check("to_idle_grant", grant, 0);
    check("to_idle_flag", timeout_flag, 0);
    tick();
    @(negedge clk);
    check("to_next_grant", grant, 4'b0010);
    tick();
    drive(1, 1'b0, 1'b0, 4'h0);
`else
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      check("stall_hold_grant", grant, 4'b0001);
      check("stall_hold_wen", fifo_w_en, 0);
    end
    tick();
    drive(0, 1'b1, 1'b1, 4'h5);
    push(0, 4'h5); push(1, 4'h4);
    @(negedge clk);
    check("stall_resume_wen", fifo_w_en, 1);
    tick();
    drive(0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    check("stall_end_busy", busy, 0);
    tick();
    @(negedge clk);
    check("stall_next_grant", grant, 4'b0010);
    tick();
    drive(1, 1'b0, 1'b0, 4'h0);
`endif

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of frame requesters, 2..8.
REQ-002 Parameter WIDTH, default 4: data word width, equal to the FIFO data_in width.
REQ-003 Parameter TIMEOUT, default 16: mid-frame stall limit in cycles, used only under REQ-025.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 srst  input  1  reset, synchronous to clk and active-high.
REQ-006 req_valid  input  NREQ  per-requester word valid.
REQ-007 req_data  input  NREQ*WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_last  input  NREQ  per-requester end-of-frame marker, qualified by req_valid.
REQ-009 req_ready  output  NREQ  per-requester word accepted this cycle when high with req_valid.
REQ-010 fifo_full  input  1  FIFO write-side full flag.
REQ-011 fifo_w_en  output  1  FIFO write enable.
REQ-012 fifo_data  output  WIDTH  FIFO write data.
REQ-013 grant  output  NREQ  one-hot owner of the FIFO write port; all zero when idle.
REQ-014 busy  output  1  high while in XFER.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and XFER.
REQ-016 IDLE behaviour:
- Any req_valid high moves the FSM to XFER next cycle.
- grant is registered with the round-robin winner: the first valid requester after last_grant, searching upward with wrap-around.
REQ-017 IDLE outputs: req_ready, fifo_w_en and grant SHALL all be zero.
REQ-018 XFER outputs, for owner g:
- req_ready[g] = ~fifo_full.
- fifo_w_en = req_valid[g] & ~fifo_full.
- fifo_data = req_data[g].
- All other req_ready bits are zero.
REQ-019 A beat SHALL be any cycle with fifo_w_en high.
- A beat with req_last[g] high returns the FSM to IDLE next cycle and loads last_grant with g.
REQ-020 Grant latency SHALL be one cycle from valid in IDLE to grant.
- One mandatory IDLE cycle separates consecutive frames.
REQ-021 While fifo_full is high, the owner SHALL keep the grant, no beat occurs, and no word is dropped or duplicated.
REQ-022 Requests from non-owners during XFER SHALL be ignored until the frame ends; the frame is never interleaved.
REQ-023 A single-word frame (valid and last in the first XFER cycle with FIFO not full) SHALL complete in exactly one XFER cycle.

Reset
REQ-024 With srst high at a rising clk edge, the block SHALL enter IDLE with these values:
- grant = 0, busy = 0, req_ready = 0, fifo_w_en = 0.
- last_grant = NREQ-1, so requester 0 wins first.
- timeout counter = 0, timeout_flag = 0.
- Reset mid-frame abandons the frame without a further beat.

Configuration
REQ-025 With macro FIFO_ARB_TIMEOUT_EN defined:
- A counter SHALL count consecutive XFER cycles where req_valid[g] is low and fifo_full is low.
- Any beat clears the counter.
- On reaching TIMEOUT, the FSM returns to IDLE, last_grant loads g, and output timeout_flag (1 bit) pulses high for one cycle.
REQ-026 With FIFO_ARB_TIMEOUT_EN not defined:
- No counter and no timeout_flag port exist.
- An owner stalled by its own invalid input keeps the grant indefinitely.

Structure
REQ-027 Package fifo_arb_pkg SHALL hold the state enum (IDLE, XFER) and the default parameter constants.
REQ-028 Sub-module rr_pick SHALL be a combinational round-robin selector with these ports:
- Inputs: request vector and last_grant index.
- Outputs: one-hot winner and any flag.

Verification
REQ-029 After srst, all four req_valid rise together -> grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between frames.
REQ-030 Requester 2 sends a 3-word frame A,B,C; fifo_full is high during the second XFER cycle -> fifo_w_en pattern 1,0,1,1 and FIFO receives A,B,C exactly once.
REQ-031 Requester 1 is mid-frame and requester 3 asserts valid -> req_ready[3] stays 0 until requester 1's last beat; grant goes to 1000 two cycles after that beat.
REQ-032 srst is asserted during the second word of a 4-word frame -> next cycle grant = 0 and fifo_w_en = 0; first grant after release goes to the lowest valid requester.
REQ-033 Build with FIFO_ARB_TIMEOUT_EN and TIMEOUT=16; the owner drops valid mid-frame -> timeout_flag pulses at the 16th stalled cycle, then the next requester is granted.
